// File: rtl/led_ctrl.sv
// LED driver with a 4-entry register file, a blink engine and optional PWM dimming.
// Define LED_CTRL_PWM_EN to compile in the PWM counter and the PWM_DUTY register.
module led_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LEDS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic [NUM_LEDS-1:0]   led
);

  logic [NUM_LEDS-1:0] value_r;
  logic [NUM_LEDS-1:0] mask_r;
  logic [23:0]         half_r;
  logic [23:0]         blink_cnt;
  logic                phase;
  logic                pwm_on;
  logic [31:0]         rd_data;

  logic sel_value, sel_mask, sel_half, sel_duty;
  assign sel_value = (address == ADDR_WIDTH'(0));
  assign sel_mask  = (address == ADDR_WIDTH'(1));
  assign sel_half  = (address == ADDR_WIDTH'(2));
  assign sel_duty  = (address == ADDR_WIDTH'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= '0;
      mask_r  <= '0;
      half_r  <= '0;
    end else if (write_enable) begin
      if (sel_value) value_r <= data_in[NUM_LEDS-1:0];
      if (sel_mask)  mask_r  <= data_in[NUM_LEDS-1:0];
      if (sel_half)  half_r  <= data_in[23:0];
    end
  end

`ifdef LED_CTRL_PWM_EN
  logic [7:0] duty_r;
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r  <= 8'hFF;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (write_enable && sel_duty) duty_r <= data_in[7:0];
    end
  end

  // Full-scale duty must stay lit even on count 255, where the compare alone would fail.
  assign pwm_on = (duty_r == 8'hFF) | (pwm_cnt < duty_r);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    if (sel_value)     rd_data[NUM_LEDS-1:0] = value_r;
    else if (sel_mask) rd_data[NUM_LEDS-1:0] = mask_r;
    else if (sel_half) rd_data[23:0]         = half_r;
`ifdef LED_CTRL_PWM_EN
    else if (sel_duty) rd_data[7:0]          = duty_r;
`endif
  end

  // Rewriting the half-period restarts the blink in the lit phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (write_enable && sel_half) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (half_r == 24'd0) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == half_r - 24'd1) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      led      <= '1;
    end else begin
      data_out <= read_enable ? rd_data : 32'd0;
      led      <= ~(value_r & (~mask_r | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}});
    end
  end

  logic unused_data;
  assign unused_data = ^data_in[31:24];

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: register table, blink/PWM sequences, and a
// randomized run checked every cycle against an arithmetic reference model.
module tb_led_ctrl;
  localparam int N = 6;
`ifdef LED_CTRL_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic        clk = 0;
  logic        rst;
  logic        write_enable, read_enable;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [N-1:0] led;

  int compared = 0;
  int mism = 0;

  led_ctrl #(.ADDR_WIDTH(8), .NUM_LEDS(N)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .data_in(data_in), .data_out(data_out), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase derived from edges elapsed since the last BLINK_HALF write.
  logic [N-1:0] m_value, m_mask, exp_led;
  int           m_half, m_duty, m_k, m_pwm;
  logic [31:0]  exp_dout;

  function automatic bit m_phase(int k, int half);
    if (half == 0) return 1'b1;
    return ((k / half) % 2) == 0;
  endfunction

  function automatic bit m_pwm_on(int cnt, int duty);
    if (!PWM) return 1'b1;
    return (duty == 255) || ((cnt % 256) < duty);
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    case (a)
      8'd0: return 32'(m_value);
      8'd1: return 32'(m_mask);
      8'd2: return 32'(m_half);
      8'd3: return PWM ? 32'(m_duty) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_value = '0; m_mask = '0; m_half = 0; m_duty = 255; m_k = 0; m_pwm = 0;
      exp_led = '1; exp_dout = '0;
    end else begin
      exp_dout = read_enable ? m_read(address) : 32'd0;
      for (int i = 0; i < N; i++)
        exp_led[i] = !(m_value[i] && (!m_mask[i] || m_phase(m_k, m_half)) && m_pwm_on(m_pwm, m_duty));
      m_k++;
      m_pwm++;
      if (write_enable) begin
        case (address)
          8'd0: m_value = data_in[N-1:0];
          8'd1: m_mask  = data_in[N-1:0];
          8'd2: begin m_half = int'(data_in[23:0]); m_k = 0; end
          8'd3: if (PWM) m_duty = int'(data_in[7:0]);
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("model_led", 32'(led), 32'(exp_led));
      chk("model_dout", data_out, exp_dout);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    write_enable = 0; read_enable = 0; address = 0; data_in = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    write_enable = 1; read_enable = 0; address = a; data_in = d;
    step();
    idle();
  endtask

  // Called just after an edge: asserts reset mid-cycle and releases it before the next edge.
  task automatic mid_reset();
    #3 rst = 1;
    #1;
    chk("rst_led", 32'(led), 32'(6'h3F));
    chk("rst_dout", data_out, 32'd0);
    #2 rst = 0;
    step();
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[17];
  int lit;

  initial begin
    vt[0]  = '{1, 0, 8'd0, 32'h15,       32'h0};
    vt[1]  = '{0, 1, 8'd0, 32'h0,        32'h15};
    vt[2]  = '{1, 1, 8'd0, 32'hFFFFFFC0, 32'h15};
    vt[3]  = '{0, 1, 8'd0, 32'h0,        32'h0};
    vt[4]  = '{1, 0, 8'd1, 32'h0A,       32'h0};
    vt[5]  = '{1, 1, 8'd1, 32'h05,       32'h0A};
    vt[6]  = '{0, 1, 8'd1, 32'h0,        32'h05};
    vt[7]  = '{1, 1, 8'd7, 32'hFF,       32'h0};
    vt[8]  = '{0, 1, 8'd1, 32'h0,        32'h05};
    vt[9]  = '{1, 0, 8'd2, 32'hFFFFFFFF, 32'h0};
    vt[10] = '{0, 1, 8'd2, 32'h0,        32'h00FFFFFF};
    vt[11] = '{1, 0, 8'd2, 32'h0,        32'h0};
    vt[12] = '{0, 1, 8'd3, 32'h0,        PWM ? 32'hFF : 32'h0};
    vt[13] = '{1, 0, 8'd3, 32'h1FF0,     32'h0};
    vt[14] = '{0, 1, 8'd3, 32'h0,        PWM ? 32'hF0 : 32'h0};
    vt[15] = '{1, 0, 8'd3, 32'hFF,       32'h0};
    vt[16] = '{0, 1, 8'd4, 32'h0,        32'h0};

    rst = 1;
    idle();
    #22 rst = 0;
    step();
    chk("reset_led", 32'(led), 32'(6'h3F));
    chk("reset_dout", data_out, 32'd0);

    // Register table
    for (int i = 0; i < 17; i++) begin
      write_enable = vt[i].we; read_enable = vt[i].re;
      address = vt[i].addr; data_in = vt[i].data;
      step();
      chk($sformatf("table_%0d", i), data_out, vt[i].exp);
    end
    idle();

    // Static write: led changes two edges after the write is driven
    wr(8'd0, 32'h15);
    chk("static_pre", 32'(led), 32'(6'h3F));
    step();
    chk("static_led", 32'(led), 32'(6'b101010));

    // Mid-cycle reset with LEDs lit and data_out non-zero
    wr(8'd0, 32'h3F);
    read_enable = 1; address = 8'd0;
    step();
    read_enable = 0;
    chk("pre_rst_dout", data_out, 32'h3F);
    mid_reset();
    read_enable = 1; address = 8'd3;
    step();
    chk("rst_duty", data_out, PWM ? 32'hFF : 32'h0);
    idle();

    // Blink, half-period 4
    wr(8'd0, 32'h3F);
    wr(8'd1, 32'h01);
    wr(8'd2, 32'd4);
    for (int m = 1; m <= 24; m++) begin
      step();
      chk($sformatf("blink_%0d", m), 32'(led), 32'((((m - 1) / 4) % 2 == 0) ? 0 : 1));
    end

    // Period rewrite at counter 7
    wr(8'd2, 32'd10);
    for (int m = 1; m <= 7; m++) step();
    wr(8'd2, 32'd3);
    chk("rewrite_edge", 32'(led), 32'd0);
    for (int m = 1; m <= 9; m++) begin
      step();
      chk($sformatf("rewrite_%0d", m), 32'(led), 32'((((m - 1) / 3) % 2 == 0) ? 0 : 1));
    end

`ifdef LED_CTRL_PWM_EN
    mid_reset();
    wr(8'd0, 32'h01);
    wr(8'd3, 32'd64);
    lit = 0;
    for (int c = 0; c < 256; c++) begin step(); if (led[0] == 1'b0) lit++; end
    chk("pwm_64", 32'(lit), 32'd64);
    wr(8'd3, 32'd0);
    step();
    lit = 0;
    for (int c = 0; c < 256; c++) begin step(); if (led[0] == 1'b0) lit++; end
    chk("pwm_0", 32'(lit), 32'd0);
    wr(8'd3, 32'd255);
    step();
    lit = 0;
    for (int c = 0; c < 256; c++) begin step(); if (led[0] == 1'b0) lit++; end
    chk("pwm_255", 32'(lit), 32'd256);
`endif

    // Randomized traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      write_enable = 1'($urandom_range(0, 1));
      read_enable  = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      address = (r < 8) ? 8'(r) : 8'($urandom_range(0, 255));
      data_in = $urandom;
      if (address == 8'd2) data_in = {8'($urandom), 24'($urandom_range(0, 6))};
      if (i % 1000 == 700) mid_reset();
      else step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8: width of the register address bus.
REQ-002 The block SHALL have parameter NUM_LEDS, default 6: number of LED outputs, 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port write_enable, input, 1 bit: register write strobe, one write per high cycle.
REQ-006 The block SHALL have port read_enable, input, 1 bit: register read strobe.
REQ-007 The block SHALL have port address, input, ADDR_WIDTH bits: register select.
REQ-008 The block SHALL have port data_in, input, 32 bits: write data.
REQ-009 The block SHALL have port data_out, output, 32 bits, registered: read data.
REQ-010 The block SHALL have port led, output, NUM_LEDS bits, registered: LED drive, active-low (0 = lit).

Function
REQ-011 The register map SHALL be:
- 0: VALUE, bits [NUM_LEDS-1:0].
- 1: BLINK_MASK, bits [NUM_LEDS-1:0].
- 2: BLINK_HALF, bits [23:0], half-period in clk cycles.
- 3: PWM_DUTY, bits [7:0].
- Unused upper bits SHALL be ignored on write and read as 0.
REQ-012 A write with write_enable=1 SHALL update the addressed register at that clk edge; writes to addresses >3 SHALL be ignored.
REQ-013 A read with read_enable=1 SHALL present the addressed register on data_out one cycle later; addresses >3 SHALL return 0; read_enable=0 SHALL drive data_out to 0 on the next edge.
REQ-014 A simultaneous read and write to the same address SHALL return the pre-write value.
REQ-015 Blink engine: 24-bit counter plus phase bit.
- BLINK_HALF=0: counter held at 0, phase held at 1.
- Otherwise: counter increments each cycle; when counter = BLINK_HALF-1 it wraps to 0 and phase toggles.
REQ-016 Any write to BLINK_HALF SHALL clear the counter to 0 and set phase to 1 at the same edge.
REQ-017 Each cycle, led[i] SHALL register ~(VALUE[i] & (~BLINK_MASK[i] | phase) & pwm_on).
- Result: 2-cycle latency from the write_enable cycle to the led change.
REQ-018 BLINK_HALF=1 SHALL toggle phase every cycle.

Reset
REQ-019 While rst=1, the block SHALL asynchronously force:
- VALUE=0, BLINK_MASK=0, BLINK_HALF=0, PWM_DUTY=255.
- Blink counter=0, phase=1, PWM counter=0.
- data_out=0, led=all ones (all LEDs dark).
REQ-020 A reset asserted mid-blink or mid-PWM SHALL discard all counter state; operation SHALL resume from the reset values on the first edge after rst falls.

Configuration
REQ-021 With macro LED_CTRL_PWM_EN defined, the PWM function SHALL be compiled in:
- Free-running 8-bit PWM counter, wrapping 255->0.
- pwm_on = (PWM_DUTY==255) | (pwm_counter < PWM_DUTY).
- PWM_DUTY=0 keeps all LEDs dark.
REQ-022 Without LED_CTRL_PWM_EN:
- No PWM counter or PWM_DUTY storage.
- pwm_on SHALL be constant 1.
- Writes to address 3 SHALL be ignored and reads of address 3 SHALL return 0.

Verification
REQ-023 Reset: assert rst mid-cycle -> led=all ones and data_out=0 immediately; reading address 3 returns 255 with LED_CTRL_PWM_EN defined, 0 without.
REQ-024 Static write: write VALUE=0x15 at edge N -> led=~0x15 (6'b101010) from edge N+2; read address 0 -> data_out=0x15 one cycle after read_enable.
REQ-025 Blink: VALUE=0x3F, BLINK_MASK=0x01, BLINK_HALF=4 -> led[0] alternates 4 cycles lit / 4 cycles dark; led[5:1] stay lit.
REQ-026 Period rewrite mid-count: set BLINK_HALF=10, then rewrite BLINK_HALF=3 at counter=7 -> phase=1 and counter=0 at that edge; first toggle 3 cycles later.
REQ-027 PWM (macro defined): VALUE=0x01, PWM_DUTY=64 -> led[0] lit exactly 64 of every 256 cycles; PWM_DUTY=0 -> never lit; PWM_DUTY=255 -> always lit.
REQ-028 Same-cycle read/write: address 1 holds 0x0A, write 0x05 to address 1 with read_enable=1 -> data_out=0x0A next cycle; a following read returns 0x05; write to address 7 -> no register changes, read of address 7 returns 0.
